// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT bit-reversal reorder buffer.
package fft_pkg;
  localparam int MAX_N_LOG = 10;
  localparam int MIN_N_LOG = 3;
  localparam int PT_W      = 11;

  typedef logic [3:0]           lg_t;
  typedef logic [MAX_N_LOG-1:0] addr_t;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
  typedef enum logic       {R_IDLE, R_RUN} rd_state_t;

  // Highest set bit of the size word, clamped to the supported range.
  function automatic lg_t size_log(input logic [PT_W-1:0] pt);
    lg_t l;
    l = lg_t'(MIN_N_LOG);
    for (int i = 0; i < PT_W; i++)
      if (pt[i] && i >= MIN_N_LOG)
        l = (i > MAX_N_LOG) ? lg_t'(MAX_N_LOG) : lg_t'(i);
    return l;
  endfunction

  function automatic addr_t last_idx(input lg_t l);
    return addr_t'({MAX_N_LOG{1'b1}} >> (MAX_N_LOG - int'(l)));
  endfunction

  // Full-width reverse, then shift so only the low l bits are mirrored.
  function automatic addr_t bitrev(input addr_t a, input lg_t l);
    addr_t r;
    for (int i = 0; i < MAX_N_LOG; i++) r[i] = a[MAX_N_LOG-1-i];
    return r >> (MAX_N_LOG - int'(l));
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: simple dual-port RAM with a registered read port.
module fft_reorder_bank #(
  parameter int DWIDTH = 32,
  parameter int AW     = 10
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [2**AW];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer (two-bank ping-pong, AXI4-Stream).
// Define FFT_REORDER_ERR_EN to add the sticky o_tlast_err framing check output.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [PT_W-1:0]   i_point,
  input  logic              i_flush,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
`ifdef FFT_REORDER_ERR_EN
  ,
  output logic              o_tlast_err
`endif
);
  bank_state_t bstate [2];
  lg_t         bank_l [2];
  logic        wsel, rsel, init;
  addr_t       wcnt, rcnt;
  rd_state_t   rstate;
  lg_t         rl;
  logic        rd_pend, rd_last, rd_bank;
  logic [1:0]  sk_cnt;
  logic [1:0][DWIDTH-1:0] sk_data;
  logic [1:0]             sk_last;
  logic [1:0][DWIDTH-1:0] bank_rdata;

  // Write side: size is taken from i_point only on the first beat of a frame.
  lg_t   wl;
  addr_t waddr;
  logic  wr_fire, w_last;

  assign wl            = (wcnt == '0) ? size_log(i_point) : bank_l[wsel];
  assign w_last        = (wcnt == last_idx(wl));
  assign waddr         = bitrev(wcnt, wl);
  assign s_axis_tready = ~init & (bstate[wsel] == B_EMPTY || bstate[wsel] == B_FILLING);
  assign wr_fire       = s_axis_tvalid & s_axis_tready;

  // Read side: a read is issued only if its data will fit in the skid buffer
  // once this cycle's pop and the in-flight read are accounted for.
  logic       pop, room, rd_issue, rd_is_last, push_idx;
  logic [2:0] occ;
  addr_t      raddr;
  lg_t        rdl;

  assign pop        = (sk_cnt != 2'd0) & m_axis_tready;
  assign occ        = 3'(sk_cnt) + 3'(rd_pend) - 3'(pop);
  assign room       = occ < 3'd2;
  assign rd_issue   = ((rstate == R_RUN) | (bstate[rsel] == B_FULL)) & room;
  assign raddr      = (rstate == R_RUN) ? rcnt : '0;
  assign rdl        = (rstate == R_RUN) ? rl : bank_l[rsel];
  assign rd_is_last = (raddr == last_idx(rdl));
  assign push_idx   = sk_cnt[0] ^ pop;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.DWIDTH(DWIDTH), .AW(MAX_N_LOG)) u_bank (
      .aclk  (aclk),
      .we    (wr_fire & ~i_flush & (wsel == 1'(b))),
      .waddr (waddr),
      .wdata (s_axis_tdata),
      .re    (rd_issue & (rsel == 1'(b))),
      .raddr (raddr),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge aclk) init <= ~aresetn;

  always_ff @(posedge aclk) begin
    if (!aresetn || i_flush) begin
      bstate[0] <= B_EMPTY;
      bstate[1] <= B_EMPTY;
      bank_l[0] <= lg_t'(MIN_N_LOG);
      bank_l[1] <= lg_t'(MIN_N_LOG);
      wsel      <= 1'b0;
      rsel      <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      rstate    <= R_IDLE;
      rl        <= lg_t'(MIN_N_LOG);
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
      rd_bank   <= 1'b0;
      sk_cnt    <= 2'd0;
      sk_data   <= '0;
      sk_last   <= '0;
    end else begin
      if (wr_fire) begin
        if (wcnt == '0) begin
          bank_l[wsel] <= wl;
          bstate[wsel] <= B_FILLING;
        end
        if (w_last) begin
          bstate[wsel] <= B_FULL;
          wcnt         <= '0;
          wsel         <= ~wsel;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      case (rstate)
        R_IDLE:
          if (bstate[rsel] == B_FULL) begin
            bstate[rsel] <= B_DRAINING;
            rl           <= bank_l[rsel];
            rstate       <= R_RUN;
          end
        default: ;
      endcase
      if (rd_issue) begin
        rd_bank <= rsel;
        rd_last <= rd_is_last;
        if (rd_is_last) begin
          bstate[rsel] <= B_EMPTY;
          rsel         <= ~rsel;
          rcnt         <= '0;
          rstate       <= R_IDLE;
        end else begin
          rcnt <= raddr + 1'b1;
        end
      end
      rd_pend <= rd_issue;

      if (pop) begin
        sk_data[0] <= sk_data[1];
        sk_last[0] <= sk_last[1];
      end
      if (rd_pend) begin
        sk_data[push_idx] <= bank_rdata[rd_bank];
        sk_last[push_idx] <= rd_last;
      end
      sk_cnt <= occ[1:0];
    end
  end

  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign m_axis_tdata  = sk_data[0];
  assign m_axis_tlast  = sk_last[0];

`ifdef FFT_REORDER_ERR_EN
  always_ff @(posedge aclk) begin
    if (!aresetn || i_flush)                      o_tlast_err <= 1'b0;
    else if (wr_fire && (s_axis_tlast != w_last)) o_tlast_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif
endmodule
